// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: widths, FSM state encodings and grant ids.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CONF_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts the cycles of one memory access; done_c flags the last ACCESS cycle.
module mem_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int unsigned MEM_LATENCY = 2,
    localparam int unsigned CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    input  logic en,
    output logic done_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !done_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done_c = (count == CNT_W'(MEM_LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch (I) and load/store (D)
// requesters with round-robin arbitration on conflict and a req/ack handshake.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_W,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 m_read,
    output logic                 m_write,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 grant_d,
    output logic [CONF_W-1:0]    conflicts
);

    arb_state_e state, state_nxt;
    grant_e     grant, grant_nxt, last_grant;
    logic       we_q;
    logic       start_c, conflict_c, access_c, done_c;

    assign access_c = (state == ARB_ACCESS);

    mem_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_wait (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (start_c),
        .en    (access_c),
        .done_c(done_c)
    );

    // Next-state and arbitration decision; the side that did not win last time wins a conflict.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        start_c    = 1'b0;
        conflict_c = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    start_c   = 1'b1;
                    state_nxt = ARB_ACCESS;
                    if (i_req && d_req) begin
                        conflict_c = 1'b1;
                        if (last_grant == GRANT_D) grant_nxt = GRANT_I;
                        else                       grant_nxt = GRANT_D;
                    end else if (d_req) begin
                        grant_nxt = GRANT_D;
                    end else begin
                        grant_nxt = GRANT_I;
                    end
                end
            end
            ARB_ACCESS: if (done_c) state_nxt = ARB_RESP;
            ARB_RESP:   state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ARB_IDLE;
            grant      <= GRANT_I;
            last_grant <= GRANT_D;
            we_q       <= 1'b0;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            grant_d    <= 1'b0;
            conflicts  <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            i_ack <= 1'b0;
            d_ack <= 1'b0;

            // Request fields are latched once at grant; later changes on the inputs are ignored.
            if (start_c) begin
                if (grant_nxt == GRANT_D) begin
                    we_q    <= d_we;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                    m_read  <= ~d_we;
                    m_write <= d_we;
                    grant_d <= 1'b1;
                end else begin
                    we_q    <= 1'b0;
                    m_addr  <= i_addr;
                    m_wdata <= '0;
                    m_read  <= 1'b1;
                    m_write <= 1'b0;
                    grant_d <= 1'b0;
                end
            end

            if (access_c && done_c) begin
                m_read  <= 1'b0;
                m_write <= 1'b0;
                if (grant == GRANT_D) begin
                    d_ack <= 1'b1;
                    if (!we_q) d_rdata <= m_rdata;
                end else begin
                    i_ack   <= 1'b1;
                    i_rdata <= m_rdata;
                end
            end

            if (state == ARB_RESP) begin
                last_grant <= grant;
                grant_d    <= 1'b0;
            end

            if (conflict_c) conflicts <= conflicts + CONF_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-schedule reference model.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        i_req, i_ack, d_req, d_we, d_ack, m_read, m_write, grant_d;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata, conflicts;

    logic        i_req1, i_ack1, d_req1, d_we1, d_ack1, m_read1, m_write1, grant_d1;
    logic [15:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1, conflicts1;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    logic        mem_load;
    logic [7:0]  mem_load_addr;
    logic [15:0] mem_load_data;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_i_rdata, exp_d_rdata;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.MEM_LATENCY(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .grant_d(grant_d), .conflicts(conflicts)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_rdata(d_rdata1), .d_ack(d_ack1),
        .m_read(m_read1), .m_write(m_write1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
        .grant_d(grant_d1), .conflicts(conflicts1)
    );

    // Memory model: combinational read, write on the clock edge while the strobe is high.
    assign m_rdata  = mem[m_addr[7:0]];
    assign m_rdata1 = m_addr1 ^ 16'h5A5A;

    always @(posedge Clk) begin
        if (mem_load)     mem[mem_load_addr] = mem_load_data;
        else if (m_write) mem[m_addr[7:0]]   = m_wdata;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload_mem();
        mem_load = 1'b1;
        for (int a = 0; a < 256; a++) begin
            mem_load_addr = 8'(a);
            mem_load_data = 16'($urandom);
            ref_mem[a]    = mem_load_data;
            tick();
        end
        mem_load = 1'b0;
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [15:0] d);
        mem_load      = 1'b1;
        mem_load_addr = a;
        mem_load_data = d;
        ref_mem[a]    = d;
        tick();
        mem_load = 1'b0;
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        i_req  = 1'b1;
        i_addr = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({m_read, m_write, i_ack, d_ack, grant_d, conflicts} !== 21'd0) begin
                miscompares++;
                $display("FAIL rst_quiet: got %h want 0", {m_read, m_write, i_ack, d_ack, grant_d, conflicts});
            end
        end
        Reset = 1'b0;
        exp_i_rdata = 16'h0000;
        exp_d_rdata = 16'h0000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) begin
                exp_i_rdata = ref_mem[0];
                i_req = 1'b0;
            end
            vectors++;
            if (i_ack !== (k == 3)) begin
                miscompares++;
                $display("FAIL rst_first_ack k=%0d: got %b want %b", k, i_ack, (k == 3));
            end
            vectors++;
            if (i_rdata !== exp_i_rdata) begin
                miscompares++;
                $display("FAIL rst_first_rdata k=%0d: got %h want %h", k, i_rdata, exp_i_rdata);
            end
        end
    endtask

    task automatic test_i_read();
        set_mem(8'h10, 16'hBEEF);
        i_req  = 1'b1;
        i_addr = 16'h0010;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) begin
                exp_i_rdata = 16'hBEEF;
                i_req = 1'b0;
            end
            vectors++;
            if ({m_read, m_write, i_ack, d_ack} !== {(k <= 2), 1'b0, (k == 3), 1'b0}) begin
                miscompares++;
                $display("FAIL iread_ctl k=%0d: got %b want %b", k, {m_read, m_write, i_ack, d_ack},
                         {(k <= 2), 1'b0, (k == 3), 1'b0});
            end
            if (k <= 2) begin
                vectors++;
                if (m_addr !== 16'h0010) begin
                    miscompares++;
                    $display("FAIL iread_addr k=%0d: got %h want 0010", k, m_addr);
                end
            end
            vectors++;
            if (i_rdata !== exp_i_rdata) begin
                miscompares++;
                $display("FAIL iread_rdata k=%0d: got %h want %h", k, i_rdata, exp_i_rdata);
            end
        end
    endtask

    task automatic test_d_write();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0020;
        d_wdata = 16'h1234;
        ref_mem[8'h20] = 16'h1234;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) d_req = 1'b0;
            vectors++;
            if ({m_read, m_write, i_ack, d_ack} !== {1'b0, (k <= 2), 1'b0, (k == 3)}) begin
                miscompares++;
                $display("FAIL dwrite_ctl k=%0d: got %b want %b", k, {m_read, m_write, i_ack, d_ack},
                         {1'b0, (k <= 2), 1'b0, (k == 3)});
            end
            if (k <= 2) begin
                vectors++;
                if ({m_addr, m_wdata} !== {16'h0020, 16'h1234}) begin
                    miscompares++;
                    $display("FAIL dwrite_bus k=%0d: got %h/%h want 0020/1234", k, m_addr, m_wdata);
                end
            end
            vectors++;
            if (d_rdata !== exp_d_rdata) begin
                miscompares++;
                $display("FAIL dwrite_rdata k=%0d: got %h want %h", k, d_rdata, exp_d_rdata);
            end
        end
    endtask

    // Both sides hold req from reset release: grants alternate I,D,I,D every L+2 cycles.
    task automatic test_conflict_alternate();
        int n, ph;
        logic [15:0] exp_conf;
        Reset = 1'b1;
        tick();
        Reset  = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0030;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0031;
        exp_i_rdata = 16'h0000;
        exp_d_rdata = 16'h0000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            n  = c / (L + 2);
            ph = c % (L + 2);
            exp_conf = 16'((c - 1) / (L + 2) + 1);
            if (ph == L + 1) begin
                if (n % 2 == 0) exp_i_rdata = ref_mem[8'h30];
                else            exp_d_rdata = ref_mem[8'h31];
            end
            vectors++;
            if ({i_ack, d_ack, grant_d} !== {(ph == L + 1) && (n % 2 == 0), (ph == L + 1) && (n % 2 == 1),
                                             (ph != 0) && (n % 2 == 1)}) begin
                miscompares++;
                $display("FAIL alt_ack_grant c=%0d: got %b", c, {i_ack, d_ack, grant_d});
            end
            vectors++;
            if ((i_ack & d_ack) !== 1'b0) begin
                miscompares++;
                $display("FAIL alt_ack_overlap c=%0d: got 1 want 0", c);
            end
            vectors++;
            if (conflicts !== exp_conf) begin
                miscompares++;
                $display("FAIL alt_conflicts c=%0d: got %0d want %0d", c, conflicts, exp_conf);
            end
            vectors++;
            if ({i_rdata, d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
                miscompares++;
                $display("FAIL alt_rdata c=%0d: got %h/%h want %h/%h", c, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0040;
        tick();
        vectors++;
        if ({m_read, grant_d} !== 2'b11) begin
            miscompares++;
            $display("FAIL rmid_access: got %b want 11", {m_read, grant_d});
        end
        tick();
        Reset = 1'b1;
        d_req = 1'b0;
        tick();
        vectors++;
        if ({m_read, m_write, d_ack, grant_d, d_rdata} !== 20'd0) begin
            miscompares++;
            $display("FAIL rmid_abort: got %h want 0", {m_read, m_write, d_ack, grant_d, d_rdata});
        end
        Reset = 1'b0;
        exp_i_rdata = 16'h0000;
        exp_d_rdata = 16'h0000;
        tick();
        i_req  = 1'b1;
        i_addr = 16'h0050;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if ({i_ack, d_ack} !== {(k == 3), 1'b0}) begin
                miscompares++;
                $display("FAIL rmid_after k=%0d: got %b want %b", k, {i_ack, d_ack}, {(k == 3), 1'b0});
            end
        end
        i_req = 1'b0;
        exp_i_rdata = ref_mem[8'h50];
        tick();
    endtask

    task automatic test_latency1();
        i_req1  = 1'b1;
        i_addr1 = 16'h0005;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 2) i_req1 = 1'b0;
            vectors++;
            if ({m_read1, i_ack1} !== {(k == 1), (k == 2)}) begin
                miscompares++;
                $display("FAIL lat1_iread k=%0d: got %b want %b", k, {m_read1, i_ack1}, {(k == 1), (k == 2)});
            end
        end
        vectors++;
        if (i_rdata1 !== 16'h5A5F) begin
            miscompares++;
            $display("FAIL lat1_rdata: got %h want 5a5f", i_rdata1);
        end
        d_req1   = 1'b1;
        d_we1    = 1'b1;
        d_addr1  = 16'h0007;
        d_wdata1 = 16'hCAFE;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 2) d_req1 = 1'b0;
            vectors++;
            if ({m_write1, d_ack1, grant_d1} !== {(k == 1), (k == 2), (k <= 2)}) begin
                miscompares++;
                $display("FAIL lat1_dwrite k=%0d: got %b want %b", k, {m_write1, d_ack1, grant_d1},
                         {(k == 1), (k == 2), (k <= 2)});
            end
        end
    endtask

    // Reference: a transaction schedule -- grant at cycle g occupies the port until g+L+2,
    // strobes in (g, g+L], ack at g+L+1; conflicts resolved against the last side served.
    task automatic test_random();
        int          g, free_at;
        logic        busy, side_d, last_d, t_we;
        logic [15:0] t_addr, t_wdata, t_rdata, exp_conf;
        logic        e_rd, e_wr, e_ia, e_da, e_gd, strobe;
        Reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        Reset = 1'b0;
        exp_i_rdata = 16'h0000;
        exp_d_rdata = 16'h0000;
        exp_conf = 16'h0000;
        last_d   = 1'b1;
        busy     = 1'b0;
        side_d   = 1'b0;
        t_we     = 1'b0;
        t_addr   = 16'h0000;
        t_wdata  = 16'h0000;
        t_rdata  = 16'h0000;
        g        = 0;
        free_at  = 0;
        for (int c = 1; c <= 4000; c++) begin
            tick();
            strobe = busy && (c > g) && (c <= g + L);
            e_rd = strobe && !t_we;
            e_wr = strobe && t_we;
            e_ia = busy && (c == g + L + 1) && !side_d;
            e_da = busy && (c == g + L + 1) && side_d;
            e_gd = busy && side_d && (c > g) && (c <= g + L + 1);
            if (e_ia) exp_i_rdata = t_rdata;
            if (e_da && !t_we) exp_d_rdata = t_rdata;
            vectors++;
            if ({m_read, m_write, i_ack, d_ack, grant_d} !== {e_rd, e_wr, e_ia, e_da, e_gd}) begin
                miscompares++;
                $display("FAIL rnd_ctl c=%0d: got %b want %b", c, {m_read, m_write, i_ack, d_ack, grant_d},
                         {e_rd, e_wr, e_ia, e_da, e_gd});
            end
            if (strobe) begin
                vectors++;
                if (m_addr !== t_addr || (t_we && m_wdata !== t_wdata)) begin
                    miscompares++;
                    $display("FAIL rnd_bus c=%0d: got %h/%h want %h/%h", c, m_addr, m_wdata, t_addr, t_wdata);
                end
            end
            vectors++;
            if ({conflicts, i_rdata, d_rdata} !== {exp_conf, exp_i_rdata, exp_d_rdata}) begin
                miscompares++;
                $display("FAIL rnd_state c=%0d: got %h/%h/%h want %h/%h/%h", c, conflicts, i_rdata, d_rdata,
                         exp_conf, exp_i_rdata, exp_d_rdata);
            end
            if (e_ia || e_da) begin
                busy   = 1'b0;
                last_d = side_d;
                if (e_ia) i_req = 1'b0;
                if (e_da) d_req = 1'b0;
            end
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = 16'($urandom_range(0, 255));
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 255));
                d_wdata = 16'($urandom);
            end
            if (!busy && c >= free_at && (i_req || d_req)) begin
                if (i_req && d_req) begin
                    side_d   = !last_d;
                    exp_conf = exp_conf + 16'd1;
                end else begin
                    side_d = d_req;
                end
                busy    = 1'b1;
                g       = c;
                free_at = c + L + 2;
                if (side_d) begin
                    t_we    = d_we;
                    t_addr  = d_addr;
                    t_wdata = d_wdata;
                end else begin
                    t_we    = 1'b0;
                    t_addr  = i_addr;
                    t_wdata = 16'h0000;
                end
                if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
                else      t_rdata = ref_mem[t_addr[7:0]];
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        i_req    = 1'b0;
        i_addr   = 16'h0000;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 16'h0000;
        d_wdata  = 16'h0000;
        i_req1   = 1'b0;
        i_addr1  = 16'h0000;
        d_req1   = 1'b0;
        d_we1    = 1'b0;
        d_addr1  = 16'h0000;
        d_wdata1 = 16'h0000;
        mem_load      = 1'b0;
        mem_load_addr = 8'h00;
        mem_load_data = 16'h0000;
        exp_i_rdata   = 16'h0000;
        exp_d_rdata   = 16'h0000;
        preload_mem();
        test_reset();
        test_i_read();
        test_d_write();
        test_conflict_alternate();
        test_reset_mid();
        test_latency1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
